// File: rtl/frame_wr_ctrl_if.sv
// rtl/frame_wr_ctrl_if.sv - burst write bus between frame_wr_ctrl and the memory writer
interface frame_wr_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 7
);
  logic              wr_req_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [LEN_W-1:0]  wr_len_o;
  logic              wr_ack_i;
  logic [DATA_W-1:0] wr_data_o;
  logic              wr_data_rd_i;

  modport master (
    output wr_req_o, wr_addr_o, wr_len_o, wr_data_o,
    input  wr_ack_i, wr_data_rd_i
  );

  modport slave (
    input  wr_req_o, wr_addr_o, wr_len_o, wr_data_o,
    output wr_ack_i, wr_data_rd_i
  );
endinterface

// File: rtl/frame_wr_ctrl.sv
// rtl/frame_wr_ctrl.sv - captures one frame into a FIFO and drains it as address-generated write bursts
module frame_wr_ctrl #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 32,
  parameter int                H_ACT      = 1280,
  parameter int                V_ACT      = 720,
  parameter int                BURST_LEN  = 64,
  parameter int                FIFO_DEPTH = 256,
  parameter int                FB_NUM     = 3,
  parameter logic [ADDR_W-1:0] FB_BASE    = 32'h0100_0000,
  parameter logic [ADDR_W-1:0] FB_STRIDE  = 32'h0080_0000
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      fs_cap_i,
  input  logic                      de_i,
  input  logic [DATA_W-1:0]         data_i,
  output logic                      s_rdy_o,
  frame_wr_ctrl_if.master           wr,
  output logic                      frame_done_o,
  output logic [$clog2(FB_NUM):0]   done_fb_o,
  output logic                      ovf_o
);
  localparam int LEN_W = $clog2(BURST_LEN) + 1;
  localparam int FB_W  = $clog2(FB_NUM) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TOTAL = H_ACT * V_ACT;
  localparam int PIX_W = $clog2(TOTAL) + 1;
  localparam int BYTES = DATA_W / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              s_rdy_q, s_rdy_d;
  logic [FB_W-1:0]   fb_idx_q, fb_idx_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              ovf_q, ovf_d;
  logic              req_q, req_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              out_q, out_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;
  logic [FB_W-1:0]   done_fb_q, done_fb_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic full, empty, push, drop, pop, hs, busy, draining;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = (state_q == ST_ACTIVE) && de_i && !full;
  assign drop     = (state_q == ST_ACTIVE) && de_i && full;
  assign pop      = wr.wr_data_rd_i && out_q && !empty;
  assign hs       = req_q && wr.wr_ack_i;
  assign busy     = req_q || out_q;
  assign draining = (state_q == ST_ACTIVE) || (state_q == ST_FLUSH);

  assign s_rdy_o      = s_rdy_q;
  assign ovf_o        = ovf_q;
  assign frame_done_o = done_q;
  assign done_fb_o    = done_fb_q;
  assign wr.wr_req_o  = req_q;
  assign wr.wr_addr_o = cur_addr_q;
  assign wr.wr_len_o  = len_q;
  assign wr.wr_data_o = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_rdy_d    = s_rdy_q;
    fb_idx_d   = fb_idx_q;
    fb_addr_d  = fb_addr_q;
    cur_addr_d = cur_addr_q;
    pix_cnt_d  = pix_cnt_q;
    ovf_d      = ovf_q;
    req_d      = req_q;
    len_d      = len_q;
    out_d      = out_q;
    beats_d    = beats_q;
    done_d     = 1'b0;
    done_fb_d  = done_fb_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    // A burst stays outstanding from its ack until its last beat is popped.
    if (hs) begin
      req_d      = 1'b0;
      out_d      = 1'b1;
      beats_d    = len_q;
      cur_addr_d = cur_addr_q + ADDR_W'(len_q) * ADDR_W'(BYTES);
    end else if (pop) begin
      beats_d = beats_q - LEN_W'(1);
      if (beats_q == LEN_W'(1)) begin
        out_d = 1'b0;
      end
    end

    if (draining && !busy) begin
      if (count_q >= CNT_W'(BURST_LEN)) begin
        req_d = 1'b1;
        len_d = LEN_W'(BURST_LEN);
      end else if ((state_q == ST_FLUSH) && !empty) begin
        req_d = 1'b1;
        len_d = LEN_W'(count_q);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (fs_cap_i) begin
          cur_addr_d = fb_addr_q;
          pix_cnt_d  = '0;
          ovf_d      = 1'b0;
          s_rdy_d    = 1'b0;
          state_d    = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Dropped pixels still count so the frame length never shifts.
        if (de_i) begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
          if (pix_cnt_q == PIX_W'(TOTAL - 1)) begin
            state_d = ST_FLUSH;
          end
        end
        if (drop) begin
          ovf_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (empty && !busy) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          done_fb_d = fb_idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_rdy_d = 1'b1;
        if (fb_idx_q == FB_W'(FB_NUM - 1)) begin
          fb_idx_d  = '0;
          fb_addr_d = FB_BASE;
        end else begin
          fb_idx_d  = fb_idx_q + FB_W'(1);
          fb_addr_d = fb_addr_q + FB_STRIDE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      s_rdy_q    <= 1'b1;
      fb_idx_q   <= '0;
      fb_addr_q  <= FB_BASE;
      cur_addr_q <= '0;
      pix_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      req_q      <= 1'b0;
      len_q      <= '0;
      out_q      <= 1'b0;
      beats_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      done_fb_q  <= '0;
    end else begin
      state_q    <= state_d;
      s_rdy_q    <= s_rdy_d;
      fb_idx_q   <= fb_idx_d;
      fb_addr_q  <= fb_addr_d;
      cur_addr_q <= cur_addr_d;
      pix_cnt_q  <= pix_cnt_d;
      ovf_q      <= ovf_d;
      req_q      <= req_d;
      len_q      <= len_d;
      out_q      <= out_d;
      beats_q    <= beats_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      done_fb_q  <= done_fb_d;
    end
  end
endmodule

// File: tb/tb_frame_wr_ctrl.sv
// tb/tb_frame_wr_ctrl.sv - directed scoreboard bench for frame_wr_ctrl
module tb_frame_wr_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              fs = 1'b0;
  logic              de = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              s_rdy, frame_done, ovf;
  logic [2:0]        done_fb;

  frame_wr_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  frame_wr_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .H_ACT(10), .V_ACT(3), .BURST_LEN(8),
    .FIFO_DEPTH(16), .FB_NUM(3), .FB_BASE(32'h1000), .FB_STRIDE(32'h800)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .fs_cap_i(fs), .de_i(de), .data_i(data),
    .s_rdy_o(s_rdy), .wr(bus.master), .frame_done_o(frame_done),
    .done_fb_o(done_fb), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int beats = 0;
  int len_cap = 0;
  bit ack_pend = 0;
  bit ack_en = 1;
  bit spur_rd = 0;

  logic [DATA_W-1:0] exp_data [$];
  logic [ADDR_W-1:0] exp_addr [$];
  int                exp_len  [$];
  int                exp_done [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed unexpected event expected none", tag);
  endtask

  // One clock: monitor done pulses and act as the downstream burst writer.
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) begin
      done_cnt++;
      if (exp_done.size() == 0) fail_now("done_extra");
      else check("done_fb", 64'(done_fb), 64'(exp_done.pop_front()));
    end
    bus.wr_ack_i     = 1'b0;
    bus.wr_data_rd_i = 1'b0;
    if (ack_pend) begin
      ack_pend = 0;
      beats    = len_cap;
    end
    if (beats > 0) begin
      if (exp_data.size() == 0) fail_now("data_extra");
      else check("wr_data", 64'(bus.wr_data_o), 64'(exp_data.pop_front()));
      bus.wr_data_rd_i = 1'b1;
      beats--;
    end else begin
      if (spur_rd) bus.wr_data_rd_i = 1'b1;
      if (bus.wr_req_o && ack_en) begin
        if (exp_addr.size() == 0) fail_now("req_extra");
        else begin
          check("req_addr", 64'(bus.wr_addr_o), 64'(exp_addr.pop_front()));
          check("req_len", 64'(bus.wr_len_o), 64'(exp_len.pop_front()));
        end
        bus.wr_ack_i = 1'b1;
        ack_pend     = 1;
        len_cap      = int'(bus.wr_len_o);
      end
    end
  endtask

  task automatic start_frame(input int fb, input logic [ADDR_W-1:0] addr, input int n_full, input int rem);
    for (int i = 0; i < n_full; i++) begin
      exp_addr.push_back(addr + ADDR_W'(i * 16));
      exp_len.push_back(8);
    end
    if (rem > 0) begin
      exp_addr.push_back(addr + ADDR_W'(n_full * 16));
      exp_len.push_back(rem);
    end
    exp_done.push_back(fb);
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic drive(input int n, input int base, input int keep, input int fs_at);
    for (int i = 0; i < n; i++) begin
      de   = 1'b1;
      data = DATA_W'(base + i);
      fs   = (i == fs_at);
      if (i < keep) exp_data.push_back(DATA_W'(base + i));
      tick();
    end
    de = 1'b0;
    fs = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int k = 0; k < budget && done_cnt == start; k++) tick();
    if (done_cnt == start) fail_now("done_timeout");
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_s_rdy"}, 64'(s_rdy), 64'd1);
    check({pfx, "_req"}, 64'(bus.wr_req_o), 64'd0);
    check({pfx, "_addr"}, 64'(bus.wr_addr_o), 64'd0);
    check({pfx, "_len"}, 64'(bus.wr_len_o), 64'd0);
    check({pfx, "_data"}, 64'(bus.wr_data_o), 64'd0);
    check({pfx, "_done"}, 64'(frame_done), 64'd0);
    check({pfx, "_done_fb"}, 64'(done_fb), 64'd0);
    check({pfx, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  task automatic frame_end(input string pfx);
    tick();
    check({pfx, "_s_rdy_back"}, 64'(s_rdy), 64'd1);
    check({pfx, "_reqs_left"}, 64'(exp_addr.size()), 64'd0);
    check({pfx, "_data_left"}, 64'(exp_data.size()), 64'd0);
  endtask

  initial begin
    bus.wr_ack_i     = 1'b0;
    bus.wr_data_rd_i = 1'b0;
    #12;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Frame 1: buffer 0, continuous pixels, prompt downstream.
    start_frame(0, 32'h1000, 3, 6);
    check("f1_s_rdy_low", 64'(s_rdy), 64'd0);
    drive(30, 0, 30, -1);
    wait_done(100);
    frame_end("f1");

    // Frame 2: buffer 1, frame-start pulses in ACTIVE and FLUSH are ignored.
    start_frame(1, 32'h1800, 3, 6);
    drive(30, 100, 30, 5);
    check("f2_s_rdy_active", 64'(s_rdy), 64'd0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    check("f2_s_rdy_flush", 64'(s_rdy), 64'd0);
    wait_done(100);
    frame_end("f2");

    // Frame 3: buffer 2, ack withheld so the 16-deep FIFO overflows.
    ack_en = 0;
    start_frame(2, 32'h2000, 2, 0);
    drive(30, 200, 16, -1);
    check("f3_ovf_set", 64'(ovf), 64'd1);
    repeat (4) tick();
    check("f3_req_held", 64'(bus.wr_req_o), 64'd1);
    check("f3_req_addr_held", 64'(bus.wr_addr_o), 64'h2000);
    ack_en = 1;
    wait_done(100);
    check("f3_ovf_sticky", 64'(ovf), 64'd1);
    frame_end("f3");

    // Frame 4: spurious pops while idle and between bursts, push+pop at count 8.
    spur_rd = 1;
    repeat (3) tick();
    spur_rd = 0;
    check("idle_count", 64'(dut.count_q), 64'd0);
    check("idle_data", 64'(bus.wr_data_o), 64'd0);
    check("idle_req", 64'(bus.wr_req_o), 64'd0);
    ack_en = 0;
    start_frame(0, 32'h1000, 3, 6);
    check("f4_ovf_cleared", 64'(ovf), 64'd0);
    drive(8, 300, 8, -1);
    spur_rd = 1;
    tick();
    tick();
    spur_rd = 0;
    check("gap_count", 64'(dut.count_q), 64'd8);
    check("gap_req", 64'(bus.wr_req_o), 64'd1);
    ack_en = 1;
    tick();
    tick();
    de   = 1'b1;
    data = DATA_W'(308);
    exp_data.push_back(DATA_W'(308));
    tick();
    de = 1'b0;
    check("pushpop_count", 64'(dut.count_q), 64'd8);
    drive(21, 309, 21, -1);
    wait_done(100);
    frame_end("f4");

    // Frame 5: reset dropped after 3 of 8 beats of the first burst.
    start_frame(1, 32'h1800, 3, 6);
    drive(8, 400, 8, -1);
    for (int k = 0; k < 50 && beats != 5; k++) tick();
    if (beats != 5) fail_now("rst_wait_timeout");
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    bus.wr_ack_i     = 1'b0;
    bus.wr_data_rd_i = 1'b0;
    beats    = 0;
    ack_pend = 0;
    exp_data.delete();
    exp_addr.delete();
    exp_len.delete();
    exp_done.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    check("post_rst_s_rdy", 64'(s_rdy), 64'd1);
    check("post_rst_req", 64'(bus.wr_req_o), 64'd0);

    // Frame 6: restarts at buffer 0.
    start_frame(0, 32'h1000, 3, 6);
    drive(30, 500, 30, -1);
    wait_done(100);
    frame_end("f6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
